// File: rtl/agu_rdport_if.sv
// Address-in / read-data-out handshake bundle between the AGU, the read-port responder
// and the MVU consumer. The master side issues addresses and takes data; the slave responds.
interface agu_rdport_if #(
    parameter int BWADDR = 21,
    parameter int BWDATA = 64
);
    logic [BWADDR-1:0] addr_in;
    logic              addr_valid;
    logic              addr_ready;
    logic [BWDATA-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output addr_in, addr_valid, rd_ready,
        input  addr_ready, rd_data, rd_valid
    );

    modport slave (
        input  addr_in, addr_valid, rd_ready,
        output addr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/agu_rdport.sv
// In-order read responder: sync RAM (S1) + output register (S2) + credit-tracked response FIFO.
// Optional range check on upper address bits is compiled in with AGU_RDPORT_OOB_CHECK_EN.
module agu_rdport #(
    parameter int BWADDR     = 21,
    parameter int BWDATA     = 64,
    parameter int DEPTH_LOG2 = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    agu_rdport_if.slave           bus,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [BWDATA-1:0]     wr_data,
    output logic                  err_oob,
    output logic [BWADDR-1:0]     err_addr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    logic [BWDATA-1:0]     ram [2**DEPTH_LOG2];
    logic [BWDATA-1:0]     fifo_q [FIFO_DEPTH];

    logic                  vld_p1_q, vld_p2_q, oob_p1_q;
    logic [BWDATA-1:0]     ram_rd_p1_q, data_p2_q;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d, cnt_q, cnt_d;

    logic                  accept_p0, oob_p0, push, pop;
    logic [DEPTH_LOG2-1:0] idx_p0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Credit is granted from registered occupancy only, so a pop frees a slot one cycle later.
    assign bus.addr_ready = (occ_q < OCC_MAX);
    assign accept_p0      = bus.addr_valid && bus.addr_ready;
    assign idx_p0         = bus.addr_in[DEPTH_LOG2-1:0];
    assign push           = vld_p2_q;
    assign bus.rd_valid   = (cnt_q != '0);
    assign pop            = bus.rd_valid && bus.rd_ready;
    assign bus.rd_data    = bus.rd_valid ? fifo_q[rptr_q] : '0;

`ifdef AGU_RDPORT_OOB_CHECK_EN
    logic              err_oob_q;
    logic [BWADDR-1:0] err_addr_q;

    assign oob_p0   = |bus.addr_in[BWADDR-1:DEPTH_LOG2];
    assign err_oob  = err_oob_q;
    assign err_addr = err_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob_q  <= 1'b0;
            err_addr_q <= '0;
        end else if (accept_p0 && oob_p0 && !err_oob_q) begin
            err_oob_q  <= 1'b1;
            err_addr_q <= bus.addr_in;
        end
    end
`else
    logic addr_hi_unused;

    assign addr_hi_unused = ^bus.addr_in[BWADDR-1:DEPTH_LOG2];
    assign oob_p0         = 1'b0;
    assign err_oob        = 1'b0;
    assign err_addr       = '0;
`endif

    always_comb begin
        occ_d  = occ_q;
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        case ({accept_p0, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);
    end

    // Write port; a same-edge read of the same word sees the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    // S1: registered RAM read (suppressed for out-of-range addresses)
    always_ff @(posedge clk) begin
        if (accept_p0 && !oob_p0) ram_rd_p1_q <= ram[idx_p0];
        oob_p1_q <= oob_p0;
    end

    // S2: output register; out-of-range responses carry zero data
    always_ff @(posedge clk) begin
        data_p2_q <= oob_p1_q ? '0 : ram_rd_p1_q;
        if (push) fifo_q[wptr_q] <= data_p2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            occ_q    <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            vld_p1_q <= accept_p0;
            vld_p2_q <= vld_p1_q;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end
endmodule

// File: tb/tb_agu_rdport.sv
// Directed bench for agu_rdport: reset, streaming, back-pressure, read-first, range check,
// and reset with reads in flight.
module tb_agu_rdport;
    localparam int BWADDR     = 21;
    localparam int BWDATA     = 64;
    localparam int DEPTH_LOG2 = 10;
    localparam int FIFO_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [BWDATA-1:0]     wr_data;
    logic                  err_oob;
    logic [BWADDR-1:0]     err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    agu_rdport_if #(.BWADDR(BWADDR), .BWDATA(BWDATA)) bus ();

    agu_rdport #(
        .BWADDR(BWADDR), .BWDATA(BWDATA), .DEPTH_LOG2(DEPTH_LOG2), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_oob(err_oob), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus.addr_valid = 1'b0; bus.addr_in = '0; bus.rd_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        n_checks++; if (bus.addr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_addr_ready got %b want 1", bus.addr_ready); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL reset_err_oob got %b want 0", err_oob); end
        n_checks++; if (err_addr !== '0) begin n_fail++; $display("FAIL reset_err_addr got %h want 0", err_addr); end
        step();
        n_checks++; if (bus.addr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_addr_ready2 got %b want 1", bus.addr_ready); end
    endtask

    task automatic test_stream();
        logic              exp_v;
        logic [BWDATA-1:0] exp_d;
        for (int k = 0; k < 16; k++) begin
            wr_en = 1'b1; wr_addr = DEPTH_LOG2'(k); wr_data = BWDATA'(k) * 64'h1111;
            step();
        end
        wr_en = 1'b0;
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            exp_v = (c >= 3 && c < 19);
            bus.addr_valid = (c < 16);
            bus.addr_in    = BWADDR'(c);
            if (c < 16) begin
                n_checks++;
                if (bus.addr_ready !== 1'b1) begin n_fail++; $display("FAIL stream_addr_ready c=%0d got %b want 1", c, bus.addr_ready); end
            end
            n_checks++;
            if (bus.rd_valid !== exp_v) begin n_fail++; $display("FAIL stream_rd_valid c=%0d got %b want %b", c, bus.rd_valid, exp_v); end
            if (exp_v) begin
                exp_d = BWDATA'(c - 3) * 64'h1111;
                n_checks++;
                if (bus.rd_data !== exp_d) begin n_fail++; $display("FAIL stream_rd_data c=%0d got %h want %h", c, bus.rd_data, exp_d); end
            end
            step();
        end
        bus.addr_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int                n_acc;
        int                popped;
        logic [BWDATA-1:0] exp_d;
        n_acc = 0;
        bus.rd_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.addr_valid = 1'b1;
            bus.addr_in    = BWADDR'(n_acc + 1);
            if (bus.addr_ready) n_acc++;
            step();
        end
        n_checks++; if (n_acc !== 4) begin n_fail++; $display("FAIL bp_accepts got %0d want 4", n_acc); end
        n_checks++; if (bus.addr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", bus.addr_ready); end
        n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got %b want 1", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 64'h1111) begin n_fail++; $display("FAIL bp_hold_data got %h want 1111", bus.rd_data); end
        bus.addr_in  = BWADDR'(5);
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        n_checks++; if (bus.addr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_credit_return got %b want 1", bus.addr_ready); end
        n_checks++; if (bus.rd_data !== 64'h2222) begin n_fail++; $display("FAIL bp_head_after_pop got %h want 2222", bus.rd_data); end
        step();
        n_checks++; if (bus.addr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_refull_ready got %b want 0", bus.addr_ready); end
        bus.addr_valid = 1'b0;
        bus.rd_ready   = 1'b1;
        popped = 0;
        for (int c = 0; c < 20 && popped < 4; c++) begin
            if (bus.rd_valid) begin
                exp_d = BWDATA'(popped + 2) * 64'h1111;
                n_checks++;
                if (bus.rd_data !== exp_d) begin n_fail++; $display("FAIL bp_drain_data i=%0d got %h want %h", popped, bus.rd_data, exp_d); end
                popped++;
            end
            step();
        end
        n_checks++; if (popped !== 4) begin n_fail++; $display("FAIL bp_drain_count got %0d want 4", popped); end
        step(); step();
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained_valid got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_read_first();
        logic [BWDATA-1:0] exp_d [2];
        int                got;
        exp_d[0] = 64'hAA;
        exp_d[1] = 64'hBB;
        bus.rd_ready = 1'b1;
        wr_en = 1'b1; wr_addr = DEPTH_LOG2'(5); wr_data = 64'hAA;
        step();
        wr_data = 64'hBB;
        bus.addr_valid = 1'b1; bus.addr_in = BWADDR'(5);
        step();
        wr_en = 1'b0;
        step();
        bus.addr_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            if (bus.rd_valid) begin
                n_checks++;
                if (bus.rd_data !== exp_d[got]) begin n_fail++; $display("FAIL rdfirst_data i=%0d got %h want %h", got, bus.rd_data, exp_d[got]); end
                got++;
            end
            step();
        end
        n_checks++; if (got !== 2) begin n_fail++; $display("FAIL rdfirst_count got %0d want 2", got); end
    endtask

    task automatic test_oob();
        logic [BWDATA-1:0] exp_d;
        logic              exp_err;
        logic [BWADDR-1:0] exp_eaddr;
        int                got;
`ifdef AGU_RDPORT_OOB_CHECK_EN
        exp_d = '0; exp_err = 1'b1; exp_eaddr = BWADDR'(21'h400);
`else
        exp_d = 64'h1234; exp_err = 1'b0; exp_eaddr = '0;
`endif
        bus.rd_ready = 1'b1;
        wr_en = 1'b1; wr_addr = '0; wr_data = 64'h1234;
        step();
        wr_en = 1'b0;
        bus.addr_valid = 1'b1; bus.addr_in = BWADDR'(21'h400);
        step();
        bus.addr_in = BWADDR'(21'h800);
        step();
        bus.addr_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            if (bus.rd_valid) begin
                n_checks++;
                if (bus.rd_data !== exp_d) begin n_fail++; $display("FAIL oob_data i=%0d got %h want %h", got, bus.rd_data, exp_d); end
                got++;
            end
            step();
        end
        n_checks++; if (got !== 2) begin n_fail++; $display("FAIL oob_count got %0d want 2", got); end
        n_checks++; if (err_oob !== exp_err) begin n_fail++; $display("FAIL oob_flag got %b want %b", err_oob, exp_err); end
        n_checks++; if (err_addr !== exp_eaddr) begin n_fail++; $display("FAIL oob_addr got %h want %h", err_addr, exp_eaddr); end
    endtask

    task automatic test_reset_midburst();
        int got;
        wr_en = 1'b1; wr_addr = DEPTH_LOG2'(7); wr_data = 64'h7777;
        step();
        wr_en = 1'b0;
        bus.rd_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.addr_valid = 1'b1; bus.addr_in = BWADDR'(k);
            step();
        end
        n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill_valid got %b want 1", bus.rd_valid); end
        rst = 1'b1; bus.rd_ready = 1'b1; bus.addr_in = BWADDR'(9);
        step();
        rst = 1'b0; bus.addr_valid = 1'b0;
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.addr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b want 1", bus.addr_ready); end
        n_checks++; if (bus.rd_data !== '0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", bus.rd_data); end
        n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b want 0", err_oob); end
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale c=%0d got %b want 0", c, bus.rd_valid); end
            step();
        end
        bus.addr_valid = 1'b1; bus.addr_in = BWADDR'(7);
        step();
        bus.addr_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got < 1; c++) begin
            if (bus.rd_valid) begin
                n_checks++;
                if (bus.rd_data !== 64'h7777) begin n_fail++; $display("FAIL mid_after_data got %h want 7777", bus.rd_data); end
                got++;
            end
            step();
        end
        n_checks++; if (got !== 1) begin n_fail++; $display("FAIL mid_after_count got %0d want 1", got); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_read_first();
        test_oob();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
